// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the fetch/data memory arbiter
package mem_arbiter_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [XLEN/8-1:0] be;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and slave signal bundle seen by the memory arbiter
interface mem_arbiter_if #(
    parameter int XLEN = mem_arbiter_pkg::XLEN
);
    logic              i_req;
    logic [XLEN-1:0]   i_addr;
    logic              i_ack;
    logic              i_err;
    logic [XLEN-1:0]   i_rdata;
    logic              d_req;
    logic              d_we;
    logic [XLEN-1:0]   d_addr;
    logic [XLEN-1:0]   d_wdata;
    logic [XLEN/8-1:0] d_be;
    logic              d_ack;
    logic              d_err;
    logic [XLEN-1:0]   d_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_be;
    logic              mem_ack;
    logic [XLEN-1:0]   mem_rdata;

    // The arbiter itself: requests and slave responses come in, grants go out.
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
        output i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    // The core requesters and the memory slave surrounding the arbiter.
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
        input  i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/mem_arbiter_watchdog.sv
// rtl/mem_arbiter_watchdog.sv - grant-state timeout counter for the memory arbiter
module arb_watchdog (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        enable,
    input  logic [15:0] limit,
    output logic        expire
);
    logic [15:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= 16'd0;
        end else if (clear) begin
            count <= 16'd0;
        end else if (enable) begin
            count <= count + 16'd1;
        end
    end

    assign expire = enable && (count == limit);
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester memory port arbiter with alternation and timeout abort
module mem_arbiter #(
    parameter int XLEN    = mem_arbiter_pkg::XLEN,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset_n,
    mem_arbiter_if.slave bus
);
    import mem_arbiter_pkg::*;

    localparam logic [1:0]  ST_IDLE  = 2'(IDLE);
    localparam logic [1:0]  ST_GNT_I = 2'(GNT_I);
    localparam logic [1:0]  ST_GNT_D = 2'(GNT_D);
    localparam logic [15:0] LIMIT    = 16'(TIMEOUT - 1);

    logic [1:0] state;
    logic [1:0] state_nx;
    mem_req_t   mem_q;
    logic       mem_req_q;
    logic       abort_q;
    logic       abort_i_q;
    logic       load_i;
    logic       load_d;
    logic       in_grant;
    logic       timeout;
    logic       i_done;
    logic       d_done;

    assign in_grant = (state != ST_IDLE);
    assign i_done   = (state == ST_GNT_I) && bus.mem_ack;
    assign d_done   = (state == ST_GNT_D) && bus.mem_ack;

    arb_watchdog u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (load_i || load_d),
        .enable  (in_grant && !bus.mem_ack),
        .limit   (LIMIT),
        .expire  (timeout)
    );

    // After a completion only the other requester is eligible; the abort cycle grants nobody.
    always_comb begin
        state_nx = state;
        load_i   = 1'b0;
        load_d   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!abort_q && bus.d_req) begin
                    load_d = 1'b1;
                end else if (!abort_q && bus.i_req) begin
                    load_i = 1'b1;
                end
            end
            ST_GNT_I: begin
                if (bus.mem_ack) begin
                    if (bus.d_req) load_d = 1'b1;
                    else           state_nx = ST_IDLE;
                end else if (timeout) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_GNT_D: begin
                if (bus.mem_ack) begin
                    if (bus.i_req) load_i = 1'b1;
                    else           state_nx = ST_IDLE;
                end else if (timeout) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        if (load_d) state_nx = ST_GNT_D;
        if (load_i) state_nx = ST_GNT_I;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            mem_q     <= '0;
            mem_req_q <= 1'b0;
            abort_q   <= 1'b0;
            abort_i_q <= 1'b0;
        end else begin
            state   <= state_nx;
            abort_q <= timeout;
            if (timeout) begin
                abort_i_q <= (state == ST_GNT_I);
            end
            if (load_d) begin
                mem_q     <= '{we: bus.d_we, addr: bus.d_addr, wdata: bus.d_wdata, be: bus.d_be};
                mem_req_q <= 1'b1;
            end else if (load_i) begin
                mem_q     <= '{we: 1'b0, addr: bus.i_addr, wdata: '0, be: '1};
                mem_req_q <= 1'b1;
            end else if (state_nx == ST_IDLE) begin
                mem_req_q <= 1'b0;
            end
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_q.we;
    assign bus.mem_addr  = mem_q.addr;
    assign bus.mem_wdata = mem_q.wdata;
    assign bus.mem_be    = mem_q.be;

    assign bus.i_ack   = i_done || (abort_q && abort_i_q);
    assign bus.i_err   = abort_q && abort_i_q;
    assign bus.i_rdata = i_done ? bus.mem_rdata : '0;
    assign bus.d_ack   = d_done || (abort_q && !abort_i_q);
    assign bus.d_err   = abort_q && !abort_i_q;
    assign bus.d_rdata = d_done ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    localparam int XLEN = 32;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;

    mem_arbiter_if #(.XLEN(XLEN)) bus ();

    mem_arbiter #(.XLEN(XLEN), .TIMEOUT(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
        bus.mem_ack = 0; bus.mem_rdata = '0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        idle_inputs();
        step(); step();
        #1;
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req got %h want 0", bus.mem_req); end
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we got %h want 0", bus.mem_we); end
        n_cmp++; if (bus.mem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_mem_addr got %h want 0", bus.mem_addr); end
        n_cmp++; if (bus.mem_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_mem_wdata got %h want 0", bus.mem_wdata); end
        n_cmp++; if (bus.mem_be !== 4'h0) begin n_bad++; $display("FAIL rst_mem_be got %h want 0", bus.mem_be); end
        n_cmp++; if ({bus.i_ack, bus.i_err, bus.d_ack, bus.d_err} !== 4'b0) begin n_bad++; $display("FAIL rst_acks got %b want 0000", {bus.i_ack, bus.i_err, bus.d_ack, bus.d_err}); end
        reset_n = 1;
        step();
    endtask

    task automatic test_lone_fetch();
        bus.i_req = 1; bus.i_addr = 32'h100;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL fetch_req_early got %h want 0", bus.mem_req); end
        step(); #1;
        n_cmp++; if (bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL fetch_mem_req got %h want 1", bus.mem_req); end
        n_cmp++; if (bus.mem_addr !== 32'h100) begin n_bad++; $display("FAIL fetch_mem_addr got %h want 100", bus.mem_addr); end
        n_cmp++; if (bus.mem_be !== 4'hF) begin n_bad++; $display("FAIL fetch_mem_be got %h want f", bus.mem_be); end
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL fetch_mem_we got %h want 0", bus.mem_we); end
        step(); step(); step();
        bus.mem_ack = 1; bus.mem_rdata = 32'hDEADBEEF;
        #1;
        n_cmp++; if (bus.i_ack !== 1'b1 || bus.i_err !== 1'b0) begin n_bad++; $display("FAIL fetch_ack got ack=%h err=%h want 1/0", bus.i_ack, bus.i_err); end
        n_cmp++; if (bus.i_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL fetch_rdata got %h want deadbeef", bus.i_rdata); end
        n_cmp++; if (bus.d_ack !== 1'b0) begin n_bad++; $display("FAIL fetch_d_ack got %h want 0", bus.d_ack); end
        step();
        bus.mem_ack = 0; bus.i_req = 0;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL fetch_idle_req got %h want 0", bus.mem_req); end
        n_cmp++; if (bus.i_ack !== 1'b0 || bus.i_rdata !== 32'h0) begin n_bad++; $display("FAIL fetch_after got ack=%h rdata=%h want 0/0", bus.i_ack, bus.i_rdata); end
        step();
    endtask

    task automatic test_simultaneous();
        bus.i_req = 1; bus.i_addr = 32'h300;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'h55; bus.d_be = 4'h3;
        step(); #1;
        n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin n_bad++; $display("FAIL sim_d_grant got req=%h we=%h want 1/1", bus.mem_req, bus.mem_we); end
        n_cmp++; if (bus.mem_addr !== 32'h200 || bus.mem_wdata !== 32'h55 || bus.mem_be !== 4'h3) begin n_bad++; $display("FAIL sim_d_latch got %h/%h/%h want 200/55/3", bus.mem_addr, bus.mem_wdata, bus.mem_be); end
        step();
        bus.mem_ack = 1; bus.mem_rdata = 32'h11;
        #1;
        n_cmp++; if (bus.d_ack !== 1'b1 || bus.i_ack !== 1'b0 || bus.d_rdata !== 32'h11) begin n_bad++; $display("FAIL sim_d_ack got d=%h i=%h rdata=%h want 1/0/11", bus.d_ack, bus.i_ack, bus.d_rdata); end
        step();
        bus.mem_ack = 0; bus.d_req = 0;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h300) begin n_bad++; $display("FAIL sim_switch got req=%h addr=%h want 1/300", bus.mem_req, bus.mem_addr); end
        n_cmp++; if (bus.mem_we !== 1'b0 || bus.mem_be !== 4'hF || bus.mem_wdata !== 32'h0) begin n_bad++; $display("FAIL sim_i_latch got we=%h be=%h wdata=%h want 0/f/0", bus.mem_we, bus.mem_be, bus.mem_wdata); end
        step();
        bus.mem_ack = 1; bus.mem_rdata = 32'h22;
        #1;
        n_cmp++; if (bus.i_ack !== 1'b1 || bus.i_rdata !== 32'h22 || bus.d_ack !== 1'b0) begin n_bad++; $display("FAIL sim_i_ack got i=%h rdata=%h d=%h want 1/22/0", bus.i_ack, bus.i_rdata, bus.d_ack); end
        step();
        bus.mem_ack = 0; bus.i_req = 0; bus.d_we = 0;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL sim_idle got %h want 0", bus.mem_req); end
        step();
    endtask

    task automatic test_back_to_back();
        bus.i_req = 1; bus.i_addr = 32'h1000;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h2000; bus.d_be = 4'hF;
        for (int k = 0; k < 8; k++) begin
            step();
            bus.mem_ack = 0;
            #1;
            n_cmp++; if (bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL b2b_req_%0d got %h want 1", k, bus.mem_req); end
            n_cmp++; if (bus.mem_we !== ((k % 2) == 0)) begin n_bad++; $display("FAIL b2b_order_%0d got we=%h want %0d", k, bus.mem_we, (k % 2) == 0); end
            step();
            bus.mem_ack = 1; bus.mem_rdata = 32'(k);
            if (k == 7) bus.d_req = 0;
            #1;
            n_cmp++; if (bus.d_ack !== ((k % 2) == 0) || bus.i_ack !== ((k % 2) == 1)) begin n_bad++; $display("FAIL b2b_ack_%0d got d=%h i=%h want d=%0d", k, bus.d_ack, bus.i_ack, (k % 2) == 0); end
            n_cmp++; if (bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL b2b_hold_%0d got %h want 1", k, bus.mem_req); end
        end
        step();
        bus.mem_ack = 0; bus.i_req = 0; bus.d_we = 0;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got %h want 0", bus.mem_req); end
        step();
    endtask

    task automatic test_timeout();
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h400; bus.d_be = 4'hF;
        bus.mem_rdata = 32'hFFFF_FFFF;
        step(); #1;
        n_cmp++; if (bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL to_req_rise got %h want 1", bus.mem_req); end
        for (int c = 1; c < 8; c++) begin
            step(); #1;
            n_cmp++; if (bus.mem_req !== 1'b1 || bus.d_ack !== 1'b0) begin n_bad++; $display("FAIL to_wait_%0d got req=%h ack=%h want 1/0", c, bus.mem_req, bus.d_ack); end
        end
        step(); #1;
        n_cmp++; if (bus.d_ack !== 1'b1 || bus.d_err !== 1'b1 || bus.d_rdata !== 32'h0) begin n_bad++; $display("FAIL to_abort got ack=%h err=%h rdata=%h want 1/1/0", bus.d_ack, bus.d_err, bus.d_rdata); end
        n_cmp++; if (bus.mem_req !== 1'b0 || bus.i_ack !== 1'b0) begin n_bad++; $display("FAIL to_drop got req=%h i_ack=%h want 0/0", bus.mem_req, bus.i_ack); end
        step();
        bus.d_req = 0;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b0 || bus.d_ack !== 1'b0) begin n_bad++; $display("FAIL to_no_regrant got req=%h ack=%h want 0/0", bus.mem_req, bus.d_ack); end
        step();
        bus.mem_ack = 1;
        #1;
        n_cmp++; if (bus.d_ack !== 1'b0 || bus.i_ack !== 1'b0 || bus.d_rdata !== 32'h0) begin n_bad++; $display("FAIL to_late_ack got d=%h i=%h rdata=%h want 0/0/0", bus.d_ack, bus.i_ack, bus.d_rdata); end
        step();
        bus.mem_ack = 0;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL to_idle got %h want 0", bus.mem_req); end
        step();
    endtask

    task automatic test_reset_mid();
        bus.i_req = 1; bus.i_addr = 32'h500;
        step(); #1;
        n_cmp++; if (bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL rm_grant got %h want 1", bus.mem_req); end
        #1;
        reset_n = 0;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b0 || bus.i_ack !== 1'b0) begin n_bad++; $display("FAIL rm_async got req=%h ack=%h want 0/0", bus.mem_req, bus.i_ack); end
        step();
        bus.mem_ack = 1;
        #1;
        n_cmp++; if (bus.i_ack !== 1'b0) begin n_bad++; $display("FAIL rm_no_ack got %h want 0", bus.i_ack); end
        bus.mem_ack = 0;
        reset_n = 1;
        step(); #1;
        n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h500) begin n_bad++; $display("FAIL rm_regrant got req=%h addr=%h want 1/500", bus.mem_req, bus.mem_addr); end
        step();
        bus.mem_ack = 1; bus.mem_rdata = 32'hCAFE;
        #1;
        n_cmp++; if (bus.i_ack !== 1'b1 || bus.i_rdata !== 32'hCAFE) begin n_bad++; $display("FAIL rm_serve got ack=%h rdata=%h want 1/cafe", bus.i_ack, bus.i_rdata); end
        step();
        bus.mem_ack = 0; bus.i_req = 0;
        step();
    endtask

    task automatic test_stray_ack();
        #1;
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL stray_pre got %h want 0", bus.mem_req); end
        bus.mem_ack = 1; bus.mem_rdata = 32'h1234;
        #1;
        n_cmp++; if (bus.i_ack !== 1'b0 || bus.d_ack !== 1'b0) begin n_bad++; $display("FAIL stray_ack got i=%h d=%h want 0/0", bus.i_ack, bus.d_ack); end
        n_cmp++; if (bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin n_bad++; $display("FAIL stray_rdata got i=%h d=%h want 0/0", bus.i_rdata, bus.d_rdata); end
        step();
        bus.mem_ack = 0;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b0 || bus.i_ack !== 1'b0 || bus.d_ack !== 1'b0) begin n_bad++; $display("FAIL stray_state got req=%h i=%h d=%h want 0/0/0", bus.mem_req, bus.i_ack, bus.d_ack); end
        step();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_lone_fetch();
        test_simultaneous();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_stray_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
